// File: rtl/lcd_hd44780_rx_if.sv
// LCD bus bundle (RS, E, D4-D7) between a 4-bit HD44780-style driver and the responder.
interface lcd_hd44780_rx_if;
    logic RS;
    logic E;
    logic D4;
    logic D5;
    logic D6;
    logic D7;

    modport master (output RS, E, D4, D5, D6, D7);
    modport slave  (input  RS, E, D4, D5, D6, D7);
endinterface

// File: rtl/lcd_hd44780_rx.sv
// HD44780-style 4-bit bus responder: synchronizes the bus, rebuilds bytes and keeps a 32-byte DDRAM image.
// Optional LCD_RX_OVERRUN_EN adds a sticky overrun output (dropped byte or too-close E falls).
module lcd_hd44780_rx #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_CHAR   = 8'h20
) (
    input  logic             CLK,
    input  logic             RST,
    lcd_hd44780_rx_if.slave  lcd,
    input  logic [4:0]       rd_addr,
    output logic [7:0]       rd_data,
    output logic             byte_valid,
    output logic [7:0]       byte_out,
    output logic             byte_rs,
    output logic [4:0]       cursor,
    output logic             mode4,
    output logic             busy
`ifdef LCD_RX_OVERRUN_EN
    ,
    output logic             overrun
`endif
);

    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } state_t;

    // Synchronizer: bit 5 = RS, bits 4:1 = D7..D4, bit 0 = E
    logic [NS-1:0][5:0] sync_q;
    logic [5:0]         bus_raw;
    logic [5:0]         bus_s;
    logic               e_prev_q;
    logic               fall;
    logic [3:0]         nib_s;
    logic               rs_s;

    assign bus_raw = {lcd.RS, lcd.D7, lcd.D6, lcd.D5, lcd.D4, lcd.E};
    assign bus_s   = sync_q[NS-1];
    assign nib_s   = bus_s[4:1];
    assign rs_s    = bus_s[5];
    assign fall    = e_prev_q & ~bus_s[0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q   <= '0;
            e_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= bus_raw;
            for (int i = 1; i < NS; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            e_prev_q <= bus_s[0];
        end
    end

    // Nibble assembly FSM
    state_t     state_q, state_d;
    logic       mode4_q, mode4_d;
    logic [3:0] hi_nib_q, hi_nib_d;
    logic       hi_rs_q, hi_rs_d;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] byte_out_q, byte_out_d;
    logic       byte_rs_q, byte_rs_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_BOOT;
            mode4_q      <= 1'b0;
            hi_nib_q     <= 4'h0;
            hi_rs_q      <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_out_q   <= 8'h00;
            byte_rs_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode4_q      <= mode4_d;
            hi_nib_q     <= hi_nib_d;
            hi_rs_q      <= hi_rs_d;
            byte_valid_q <= byte_valid_d;
            byte_out_q   <= byte_out_d;
            byte_rs_q    <= byte_rs_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode4_d      = mode4_q;
        hi_nib_d     = hi_nib_q;
        hi_rs_d      = hi_rs_q;
        byte_valid_d = 1'b0;
        byte_out_d   = byte_out_q;
        byte_rs_d    = byte_rs_q;
        if (fall) begin
            case (state_q)
                ST_BOOT: begin
                    // Only the 8-bit-mode "function set 4-bit" write leaves boot
                    if (nib_s == 4'h2 && !rs_s) begin
                        mode4_d = 1'b1;
                        state_d = ST_HI;
                    end
                end
                ST_HI: begin
                    hi_nib_d = nib_s;
                    hi_rs_d  = rs_s;
                    state_d  = ST_LO;
                end
                ST_LO: begin
                    byte_valid_d = 1'b1;
                    byte_out_d   = {hi_nib_q, nib_s};
                    byte_rs_d    = hi_rs_q;
                    state_d      = ST_HI;
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    // Byte execution, clear sequencer and the 1-deep holding register
    logic [4:0] cursor_q, cursor_d;
    logic       inc_dir_q, inc_dir_d;
    logic       busy_q, busy_d;
    logic [4:0] clr_cnt_q, clr_cnt_d;
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] hold_byte_q, hold_byte_d;
    logic       hold_rs_q, hold_rs_d;

    logic       ex_go;
    logic [7:0] ex_byte;
    logic       ex_rs;
    logic       mem_we;
    logic [4:0] mem_wa;
    logic [7:0] mem_wd;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cursor_q     <= 5'd0;
            inc_dir_q    <= 1'b1;
            busy_q       <= 1'b0;
            clr_cnt_q    <= 5'd0;
            hold_valid_q <= 1'b0;
            hold_byte_q  <= 8'h00;
            hold_rs_q    <= 1'b0;
        end else begin
            cursor_q     <= cursor_d;
            inc_dir_q    <= inc_dir_d;
            busy_q       <= busy_d;
            clr_cnt_q    <= clr_cnt_d;
            hold_valid_q <= hold_valid_d;
            hold_byte_q  <= hold_byte_d;
            hold_rs_q    <= hold_rs_d;
        end
    end

    always_comb begin
        cursor_d     = cursor_q;
        inc_dir_d    = inc_dir_q;
        busy_d       = busy_q;
        clr_cnt_d    = clr_cnt_q;
        hold_valid_d = hold_valid_q;
        hold_byte_d  = hold_byte_q;
        hold_rs_d    = hold_rs_q;
        ex_go        = 1'b0;
        ex_byte      = byte_out_q;
        ex_rs        = byte_rs_q;
        mem_we       = 1'b0;
        mem_wa       = cursor_q;
        mem_wd       = byte_out_q;

        if (busy_q) begin
            mem_we    = 1'b1;
            mem_wa    = clr_cnt_q;
            mem_wd    = FILL_CHAR;
            clr_cnt_d = clr_cnt_q + 5'd1;
            if (clr_cnt_q == 5'd31) begin
                busy_d    = 1'b0;
                cursor_d  = 5'd0;
                inc_dir_d = 1'b1;
            end
            // Queue one byte; a second arrival while the slot is full is dropped
            if (byte_valid_q && !hold_valid_q) begin
                hold_valid_d = 1'b1;
                hold_byte_d  = byte_out_q;
                hold_rs_d    = byte_rs_q;
            end
        end else if (hold_valid_q) begin
            ex_go   = 1'b1;
            ex_byte = hold_byte_q;
            ex_rs   = hold_rs_q;
            if (byte_valid_q) begin
                hold_byte_d = byte_out_q;
                hold_rs_d   = byte_rs_q;
            end else begin
                hold_valid_d = 1'b0;
            end
        end else if (byte_valid_q) begin
            ex_go = 1'b1;
        end

        if (ex_go) begin
            if (ex_rs) begin
                mem_we   = 1'b1;
                mem_wa   = cursor_q;
                mem_wd   = ex_byte;
                cursor_d = inc_dir_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
            end else if (ex_byte == 8'h01) begin
                busy_d    = 1'b1;
                clr_cnt_d = 5'd0;
            end else if (ex_byte[7:1] == 7'b0000_001) begin
                cursor_d = 5'd0;
            end else if (ex_byte[7:2] == 6'b0000_01) begin
                inc_dir_d = ex_byte[1];
            end else if (ex_byte[7]) begin
                // Line 2 starts at 0x40 on the panel; fold it onto cells 16..31
                cursor_d = {ex_byte[6], ex_byte[3:0]};
            end
        end
    end

    // DDRAM image, not reset, read asynchronously for scan-out
    logic [7:0] ddram [32];

    always_ff @(posedge CLK) begin
        if (mem_we && !RST) begin
            ddram[mem_wa] <= mem_wd;
        end
    end

    assign rd_data    = ddram[rd_addr];
    assign byte_valid = byte_valid_q;
    assign byte_out   = byte_out_q;
    assign byte_rs    = byte_rs_q;
    assign cursor     = cursor_q;
    assign mode4      = mode4_q;
    assign busy       = busy_q;

`ifdef LCD_RX_OVERRUN_EN
    logic       overrun_q, overrun_d;
    logic [2:0] gap_q, gap_d;
    logic       seen_q, seen_d;
    logic       byte_dropped;

    assign byte_dropped = busy_q & byte_valid_q & hold_valid_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            overrun_q <= 1'b0;
            gap_q     <= 3'd0;
            seen_q    <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
            gap_q     <= gap_d;
            seen_q    <= seen_d;
        end
    end

    // gap_q counts cycles since the previous falling edge, saturating at 7
    always_comb begin
        overrun_d = overrun_q | byte_dropped;
        gap_d     = (gap_q == 3'd7) ? gap_q : gap_q + 3'd1;
        seen_d    = seen_q;
        if (fall) begin
            if (seen_q && gap_q < 3'd4) begin
                overrun_d = 1'b1;
            end
            gap_d  = 3'd1;
            seen_d = 1'b1;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Directed bench for lcd_hd44780_rx: expected bytes go into a queue, a monitor checks each byte_valid pulse.
module tb_lcd_hd44780_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_data;
    logic       byte_valid;
    logic [7:0] byte_out;
    logic       byte_rs;
    logic [4:0] cursor;
    logic       mode4;
    logic       busy;
`ifdef LCD_RX_OVERRUN_EN
    logic       overrun;
`endif

    lcd_hd44780_rx_if bus ();

    lcd_hd44780_rx #(
        .SYNC_STAGES(2),
        .FILL_CHAR  (8'h20)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .lcd       (bus),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .byte_valid(byte_valid),
        .byte_out  (byte_out),
        .byte_rs   (byte_rs),
        .cursor    (cursor),
        .mode4     (mode4),
        .busy      (busy)
`ifdef LCD_RX_OVERRUN_EN
        ,
        .overrun   (overrun)
`endif
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         passes = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
            $display("check %s: %0h ok", name, act);
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge CLK) begin
        if (!RST && byte_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_byte: got rs=%0d data=%02h expected none", byte_rs, byte_out);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("rx_byte", {23'd0, byte_rs, byte_out}, {23'd0, e});
            end
        end
    end

    task automatic nibble(input logic rs, input logic [3:0] n);
        @(negedge CLK);
        bus.RS = rs;
        {bus.D7, bus.D6, bus.D5, bus.D4} = n;
        @(negedge CLK);
        bus.E = 1'b1;
        repeat (2) @(negedge CLK);
        bus.E = 1'b0;
        @(negedge CLK);
    endtask

    task automatic send(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b});
        nibble(rs, b[7:4]);
        nibble(rs, b[3:0]);
    endtask

    task automatic boot();
        nibble(1'b0, 4'h3);
        nibble(1'b0, 4'h3);
        nibble(1'b0, 4'h3);
        nibble(1'b0, 4'h2);
    endtask

    task automatic settle();
        repeat (8) @(negedge CLK);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge CLK);
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
        settle();
    endtask

    task automatic rd_check(input string name, input logic [4:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        check(name, {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.RS = 1'b0;
        bus.E  = 1'b0;
        {bus.D7, bus.D6, bus.D5, bus.D4} = 4'h0;

        do_reset();
        check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
        check("rst_byte_out",   {24'd0, byte_out},   32'd0);
        check("rst_byte_rs",    {31'd0, byte_rs},    32'd0);
        check("rst_cursor",     {27'd0, cursor},     32'd0);
        check("rst_mode4",      {31'd0, mode4},      32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);

        // 1: boot and init sequence
        nibble(1'b0, 4'h3);
        nibble(1'b0, 4'h3);
        nibble(1'b0, 4'h3);
        settle();
        check("boot_mode4_before", {31'd0, mode4}, 32'd0);
        nibble(1'b0, 4'h2);
        settle();
        check("boot_mode4_after", {31'd0, mode4}, 32'd1);
        send(1'b0, 8'h28);
        send(1'b0, 8'h0C);
        send(1'b0, 8'h06);
        settle();
        check("init_cursor", {27'd0, cursor}, 32'd0);

        // 2: clear
        send(1'b0, 8'h01);
        n = 0;
        while (!busy && n < 20) begin
            n++;
            @(negedge CLK);
        end
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge CLK);
        end
        check("clear_busy_cycles", n, 32'd32);
        settle();
        for (int a = 0; a < 32; a++) begin
            rd_check("clear_fill", a[4:0], 8'h20);
        end
        check("clear_cursor", {27'd0, cursor}, 32'd0);

        // 3: address 0, write "Th"
        send(1'b0, 8'h80);
        send(1'b1, 8'h54);
        send(1'b1, 8'h68);
        settle();
        rd_check("th_ddram0", 5'd0, 8'h54);
        rd_check("th_ddram1", 5'd1, 8'h68);
        check("th_cursor", {27'd0, cursor}, 32'd2);

        // 4: line-2 end and wrap, then decrement mode
        send(1'b0, 8'hCF);
        settle();
        check("addr_4f_cursor", {27'd0, cursor}, 32'd31);
        send(1'b1, 8'h41);
        send(1'b1, 8'h42);
        settle();
        rd_check("wrap_ddram31", 5'd31, 8'h41);
        rd_check("wrap_ddram0",  5'd0,  8'h42);
        check("wrap_cursor", {27'd0, cursor}, 32'd1);
        send(1'b0, 8'h04);
        send(1'b0, 8'h80);
        send(1'b1, 8'h5A);
        settle();
        rd_check("dec_ddram0", 5'd0, 8'h5A);
        check("dec_cursor", {27'd0, cursor}, 32'd31);

        // 5: bytes arriving during clear
        send(1'b0, 8'h01);
        send(1'b1, 8'h55);
        send(1'b1, 8'h66);
        wait_idle();
        rd_check("held_ddram0", 5'd0, 8'h55);
        rd_check("dropped_ddram1", 5'd1, 8'h20);
        check("held_cursor", {27'd0, cursor}, 32'd1);
`ifdef LCD_RX_OVERRUN_EN
        check("overrun_set", {31'd0, overrun}, 32'd1);
`endif

        // 6: reset after a lone high nibble
        nibble(1'b1, 4'h4);
        repeat (4) @(negedge CLK);
        do_reset();
        check("mid_rst_mode4",  {31'd0, mode4},  32'd0);
        check("mid_rst_cursor", {27'd0, cursor}, 32'd0);
        check("mid_rst_busy",   {31'd0, busy},   32'd0);
        nibble(1'b1, 4'h5);
        settle();
        check("boot_ignores_nibble", {31'd0, mode4}, 32'd0);
        boot();
        settle();
        check("reboot_mode4", {31'd0, mode4}, 32'd1);
        send(1'b0, 8'h80);
        send(1'b1, 8'h45);
        settle();
        rd_check("reboot_ddram0", 5'd0, 8'h45);
        check("reboot_cursor", {27'd0, cursor}, 32'd1);

        repeat (10) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_rx.md
Name: lcd_hd44780_rx

Overview:
- Synthesizable responder for the HD44780-style 4-bit LCD bus (RS, E, D4-D7) that our badge designs drive.
- Samples the bus and rebuilds bytes from nibble pairs.
- Decodes the command subset the badge uses and keeps a 32-byte DDRAM image for scan-out or checking.
- Placed in loopback tiles and on-chip self-test next to the badge driver, clocked by the same CLK.

Parameters:
- SYNC_STAGES, 2, number of flops in the synchronizer on RS/E/D4-D7 (minimum 2).
- FILL_CHAR, 8'h20, byte written to every DDRAM cell by a clear command.

Ports:
- CLK  input  1  system clock.
- RST  input  1  reset; synchronous, active-high.
- RS  input  1  register select from the driver (0 = command, 1 = data).
- E  input  1  enable strobe; the nibble is captured on its falling edge.
- D4, D5, D6, D7  input  1 each  data nibble, D7 = MSB.
- rd_addr  input  5  DDRAM read address ({line, column[3:0]}).
- rd_data  output  8  DDRAM[rd_addr], combinational read.
- byte_valid  output  1  one-cycle pulse when a byte is assembled.
- byte_out  output  8  last assembled byte; held until the next one.
- byte_rs  output  1  RS value captured with the high nibble of byte_out.
- cursor  output  5  current DDRAM write address.
- mode4  output  1  set once 4-bit mode is entered.
- busy  output  1  high while a clear command is executing.

Behaviour:
Reset values:
- byte_valid=0, byte_out=0, byte_rs=0, cursor=0, mode4=0, busy=0, inc_dir=1 (increment).
- DDRAM contents are not reset.
- Synchronizer flops reset to 0.

Sampling:
- RS/E/D pass through SYNC_STAGES flops.
- Falling edge = sync E 1 in the previous cycle and 0 now.
- RS and the nibble come from the same synchronized stage as E.
- Latency from the raw E fall to the capture cycle is SYNC_STAGES+1 CLK.

State machine:
- BOOT: each falling edge is one 8-bit-mode write using only the upper nibble.
  - Nibble 4'h3: ignored, stay in BOOT.
  - Nibble 4'h2 with RS=0: mode4=1, go to HI.
  - Any other nibble: ignored.
  - No byte_valid is issued in BOOT.
- HI: latch the nibble as byte[7:4] and latch RS, go to LO.
- LO: latch byte[3:0], pulse byte_valid the next cycle, execute the byte, go to HI.
- The RS captured in LO is ignored; byte_rs is the HI value.

Execution, RS=0 (command):
- 8'h01 clear: busy=1; write FILL_CHAR to addresses 0..31, one per cycle (32 cycles); then cursor=0, inc_dir=1, busy=0.
- 8'h02 or 8'h03 home: cursor=0.
- 8'b0000_01xx entry mode: inc_dir = bit1.
- 8'b1aaa_aaaa set DDRAM address: cursor = {a[6], a[3:0]}, so 0x40 maps to 16 and 0x4F to 31.
- Function set 8'h28/8'h2C and all other commands: no effect besides byte_valid.

Execution, RS=1 (data):
- DDRAM[cursor] <= byte in the execute cycle.
- cursor +/-1 mod 32 per inc_dir: 31+1 wraps to 0, 0-1 wraps to 31.

During busy:
- Falling edges are still assembled and the byte is queued in a 1-deep holding register, executed when the clear finishes.
- A second byte arriving while the holding register is full is dropped.

RST mid-byte or mid-clear:
- Return to BOOT, abort the clear, mode4=0.

Optional Feature:
- Macro: LCD_RX_OVERRUN_EN.
- When defined:
  - Adds output port overrun (1 bit, reset 0).
  - overrun is set sticky when a byte is dropped during busy, or when the spacing between two falling edges is under 4 CLK after sync.
  - Cleared only by RST.
- When undefined: no port, no detection logic; drops are silent.

Test Plan:
1. Boot nibbles 3,3,3,2 (RS=0), then 0x28, 0x0C, 0x06 -> mode4=1 after the 4th edge; three byte_valid pulses with byte_out 28/0C/06 and byte_rs=0; cursor=0.
2. After boot, send 0x01 -> busy high exactly 32 CLK; every rd_addr 0..31 reads 0x20; cursor=0.
3. Send 0x80 then data 'T','h' (0x54, 0x68) -> DDRAM[0]=0x54, DDRAM[1]=0x68, cursor=2.
4. Send 0xCF then data 0x41, 0x42 -> DDRAM[31]=0x41, DDRAM[0]=0x42, cursor=1 (wrap). Then send 0x04, 0x80, data 0x5A -> DDRAM[0]=0x5A, cursor=31.
5. Send 0x01 followed immediately by data 0x55 and 0x66 -> 0x55 written to DDRAM[0] after the clear, cursor=1; 0x66 dropped; with LCD_RX_OVERRUN_EN, overrun=1.
6. Assert RST after only the high nibble of 0x45 has been sent -> state BOOT, mode4=0, no byte_valid; re-boot, send 0x80 then data 0x45 -> DDRAM[0]=0x45.
